// File: rtl/bcd_8421_to_5121_conv.sv
// bcd_8421_to_5121_conv
//   Multi-digit packed 8421 BCD to packed 5121 BCD converter.
//   A word is accepted via in_valid/in_ready. It is converted one digit per
//   clock, LSD first, through a shift datapath. The result is then presented
//   via out_valid/out_ready. Each non-decimal input nibble (>9) converts to
//   0000 and sets its bit in out_err.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   input word valid
//   in_ready  out  block can accept a word (IDLE only)
//   in_data   in   packed 8421 BCD, digit i = in_data[4i+3:4i], i=0 is LSD
//   out_valid out  converted word valid (DONE only)
//   out_ready in   downstream accepts the word
//   out_data  out  packed 5121 BCD, same digit order
//   out_err   out  bit i set when input digit i was >9
module bcd_8421_to_5121_conv #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err
);

    localparam int              CNT_W = $clog2(DIGITS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [4*DIGITS-1:0] src_q;
    logic [4*DIGITS-1:0] res_q;
    logic [DIGITS-1:0]   err_q;

    logic                accept;
    logic [3:0]          nib_enc;
    logic                nib_bad;
    logic [4*DIGITS-1:0] res_ins;
    logic [DIGITS-1:0]   err_ins;

    // 8421 digit to 5121 code (weights 5,1,2,1 from bit3 down).
    always_comb begin
        nib_enc = 4'b0000;
        nib_bad = 1'b0;
        unique case (src_q[3:0])
            4'd0:    nib_enc = 4'b0000;
            4'd1:    nib_enc = 4'b0001;
            4'd2:    nib_enc = 4'b0010;
            4'd3:    nib_enc = 4'b0011;
            4'd4:    nib_enc = 4'b0111;
            4'd5:    nib_enc = 4'b1000;
            4'd6:    nib_enc = 4'b1001;
            4'd7:    nib_enc = 4'b1010;
            4'd8:    nib_enc = 4'b1011;
            4'd9:    nib_enc = 4'b1111;
            default: nib_bad = 1'b1;
        endcase
    end

    // Top-aligned insert vectors, so the shifts also work for DIGITS=1
    // without zero-width slices.
    always_comb begin
        res_ins = '0;
        err_ins = '0;
        res_ins[4*DIGITS-1 -: 4] = nib_enc;
        err_ins[DIGITS-1]        = nib_bad;
    end

    // rst_n gating keeps in_ready low while reset is held.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_err   = err_q;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CONV;
            CONV:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            src_q <= '0;
            res_q <= '0;
            err_q <= '0;
        end else if ((state_q == IDLE) && accept) begin
            cnt_q <= '0;
            src_q <= in_data;
            res_q <= '0;
            err_q <= '0;
        end else if (state_q == CONV) begin
            cnt_q <= cnt_q + CNT_W'(1);
            src_q <= src_q >> 4;
            res_q <= (res_q >> 4) | res_ins;
            err_q <= (err_q >> 1) | err_ins;
        end
    end

endmodule

// File: doc/bcd_8421_to_5121_conv.md
Name: bcd_8421_to_5121_conv

Overview:
- Multi-digit converter from packed 8421 BCD to packed 5121 BCD, the encode direction of the team's 5121-to-8421 decode path.
- Accepts one packed word via valid/ready, converts one digit per clock (LSD first) through a shift datapath, and presents the result via valid/ready.
- Flags each non-decimal input nibble.
- Sits between the BCD arithmetic/counter blocks and 5121-coded display/checker logic.

Parameters:
- DIGITS, 4, number of BCD digits per word (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  4*DIGITS  packed 8421 BCD; digit i = in_data[4i+3:4i], i=0 is LSD.
- out_valid  output  1  converted word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  4*DIGITS  packed 5121 BCD, same digit order.
- out_err  output  DIGITS  bit i set when input digit i was >9.

Behaviour:
- Digit map, 8421 to 5121 with weights 5,1,2,1 from bit3 down:
  - 0→0000, 1→0001, 2→0010, 3→0011, 4→0111
  - 5→1000, 6→1001, 7→1010, 8→1011, 9→1111
  - 10..15 → 0000, and the corresponding out_err bit is set.
- Reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- While rst_n=0:
  - in_ready=0, out_valid=0, out_data=0, out_err=0.
  - FSM=IDLE, digit counter=0, shift registers=0.
- FSM states: IDLE, CONV, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready at an edge:
    - capture in_data into the source shift register;
    - clear the result and error registers;
    - counter=0; go to CONV.
  - CONV: in_ready=0, out_valid=0. Each edge:
    - convert source nibble [3:0];
    - shift the source right 4;
    - shift the result right 4 with the converted nibble entering at the top;
    - shift err right 1 with the flag entering at the top;
    - counter+1.
    - After DIGITS conversions go to DONE. Counter width is clog2(DIGITS)+1 and it never wraps inside CONV.
  - DONE: out_valid=1; out_data and out_err are held stable. On out_valid&out_ready go to IDLE.
- Latency:
  - Input accepted at edge T.
  - out_valid is high from the cycle after edge T+DIGITS.
  - Minimum accept-to-accept spacing is DIGITS+2 cycles.
- out_data and out_err are driven directly from the result registers. They change only during CONV and are stable for the whole time out_valid=1.
- Backpressure: out_ready=0 holds DONE indefinitely, with no change on the outputs.
- in_valid during CONV or DONE is ignored. in_ready=0 there, so the upstream source must hold its word.
- Accept and release never occur in the same cycle. in_ready rises the cycle after out_valid&out_ready.
- in_data is sampled only at the accept edge. Later changes have no effect.
- rst_n asserted mid-CONV or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is emitted.
- out_valid deasserts the cycle after the out_valid&out_ready handshake, even if out_ready stays high.

Test Plan (DIGITS=4):
- Reset release, idle: rst_n low then high, no stimulus → in_ready=1, out_valid=0, out_data=16'h0000, out_err=4'b0000.
- Basic conversion: in_data=16'h1234 accepted at edge T, out_ready=1 → out_valid high after T+4, out_data=16'h1237, out_err=0; in_ready=1 one cycle after the handshake.
- Upper digits: 16'h5678 → 16'h89AB; 16'h9090 → 16'hF0F0; 16'h0000 → 16'h0000; all with out_err=0.
- Invalid digits: 16'h1A3F → out_data=16'h1030, out_err=4'b0101.
- Backpressure: 16'h9999 with out_ready=0 for 10 cycles → out_valid and out_data=16'hFFFF held stable; in_ready=0 despite in_valid=1 with 16'h1111. Then out_ready=1 → single handshake, after which 16'h1111 is accepted → 16'h1111.
- Reset mid-operation: rst_n pulsed low 2 cycles after accepting 16'h8765 → outputs at reset values immediately. No out_valid ever appears for 16'h8765, and the next word 16'h0004 converts to 16'h0007.
